// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipelined core's stage boundaries.
// The state encoding doubles as the valid bits: bit 0 = main valid, bit 1 = skid valid.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b11
    } stage_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [63:0] IF_ID_BUBBLE = {NOP_INSTR, 32'h0};

endpackage

// File: rtl/pipe_skid_stage.sv
// Pipeline-boundary register with valid/ready handshake and a one-entry skid buffer.
// in_ready comes straight from a flop so no combinational ready path crosses stages.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                 DATA_W        = 64,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL    = '0,
    parameter bit                 ZERO_ON_DRAIN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    stage_state_e      state_q;
    stage_state_e      state_d;
    logic              in_ready_q;
    logic              skid_valid;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              accept;
    logic              drain;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic              clear_main;

    assign out_valid  = state_q[0];
    assign skid_valid = state_q[1];
    assign accept     = in_valid & in_ready_q;
    assign drain      = out_valid & out_ready;

    // State register; in_ready is precomputed from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) state_d = HALF;
                HALF: begin
                    if (accept && !drain)      state_d = FULL;
                    else if (!accept && drain) state_d = EMPTY;
                end
                FULL:    if (drain) state_d = HALF;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Datapath controls; loads are gated by accept so idle in_data never leaks out.
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        clear_main     = 1'b0;
        if (flush) begin
            clear_main = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: load_main_in = accept;
                HALF: begin
                    if (accept && drain) load_main_in = 1'b1;
                    else if (accept)     load_skid    = 1'b1;
                    else if (drain)      clear_main   = ZERO_ON_DRAIN;
                end
                FULL:    load_main_skid = drain;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= BUBBLE_VAL;
            skid_q <= '0;
        end else begin
            if (clear_main)          main_q <= BUBBLE_VAL;
            else if (load_main_in)   main_q <= in_data;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = main_q;
    assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

endmodule
